// File: rtl/filter_line_ctrl.sv
// Frame sequencer for the line-buffered FN x FN filter: pixel handshake, line-buffer
// addressing, window/output marking. Optional stride-2 windows: FILTER_LINE_CTRL_STRIDE2_EN.
module filter_line_ctrl #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int FN         = 3,
    parameter int ADDR_W     = 11,
    parameter int FILTER_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              lb_wen,
    output logic [ADDR_W-1:0] lb_waddr,
    output logic              lb_ren,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic [ADDR_W-1:0] col,
    output logic [ADDR_W-1:0] row,
    output logic              win_valid,
    output logic              out_valid,
    output logic              out_last
);
    localparam int OW = IMG_W - FN + 1;
    localparam int OH = IMG_H - FN + 1;
`ifdef FILTER_LINE_CTRL_STRIDE2_EN
    localparam int NOUT = ((OW + 1) / 2) * ((OH + 1) / 2);
`else
    localparam int NOUT = OW * OH;
`endif
    localparam int OCNT_W = (NOUT > 1) ? $clog2(NOUT + 1) : 1;

    if (IMG_W - 1 >= (1 << ADDR_W)) begin : g_addr_chk
        $error("filter_line_ctrl: ADDR_W cannot address IMG_W-1");
    end

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] col_cnt, row_cnt, col_q, row_q;
    logic [OCNT_W-1:0] ocnt;
    logic              accept, last_px, win_pos, win_p1;

    assign accept   = in_valid & in_ready;
    assign last_px  = (col_cnt == ADDR_W'(IMG_W - 1)) && (row_cnt == ADDR_W'(IMG_H - 1));
    assign lb_wen   = accept;
    assign lb_waddr = col_cnt;
    assign col      = col_q;
    assign row      = row_q;
    assign out_last = out_valid && (ocnt == OCNT_W'(NOUT - 1));

`ifdef FILTER_LINE_CTRL_STRIDE2_EN
    // Origins on even offsets from the first full window only.
    localparam bit FNM1_ODD = ((FN - 1) % 2) == 1;
    assign win_pos = (int'(row_cnt) >= FN - 1) && (int'(col_cnt) >= FN - 1) &&
                     (row_cnt[0] == FNM1_ODD) && (col_cnt[0] == FNM1_ODD);
`else
    assign win_pos = (int'(row_cnt) >= FN - 1) && (int'(col_cnt) >= FN - 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                busy = start & ~reset;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && last_px) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (out_last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            ocnt      <= '0;
            lb_ren    <= 1'b0;
            lb_raddr  <= '0;
            win_p1    <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            lb_ren    <= accept;
            lb_raddr  <= col_cnt;
            // Two stages: line-buffer read, then window register load.
            win_p1    <= accept & win_pos;
            win_valid <= win_p1;
            if (state == IDLE && start) begin
                col_cnt <= '0;
                row_cnt <= '0;
                col_q   <= '0;
                row_q   <= '0;
                ocnt    <= '0;
            end else begin
                if (accept) begin
                    col_q <= col_cnt;
                    row_q <= row_cnt;
                    if (col_cnt == ADDR_W'(IMG_W - 1)) begin
                        col_cnt <= '0;
                        if (!last_px) row_cnt <= row_cnt + 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
                if (out_valid) ocnt <= ocnt + 1'b1;
            end
        end
    end

    if (FILTER_LAT == 0) begin : g_nolat
        assign out_valid = win_valid;
    end else begin : g_lat
        logic [FILTER_LAT-1:0] vld_pipe;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) vld_pipe <= '0;
            else       vld_pipe <= (vld_pipe << 1) | FILTER_LAT'(win_valid);
        end
        assign out_valid = vld_pipe[FILTER_LAT-1];
    end
endmodule

// File: tb/tb_filter_line_ctrl.sv
// Randomized scoreboard bench for filter_line_ctrl: two configurations (8x6 FN=3 LAT=2,
// 4x2 FN=1 LAT=0) checked against a position/window model driven from observed accepts.
module tb_filter_line_ctrl;
    localparam int AW = 11;
`ifdef FILTER_LINE_CTRL_STRIDE2_EN
    localparam bit S2 = 1'b1;
`else
    localparam bit S2 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [1:0] st, iv, rdy, dn, anyout;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int W = (g == 0) ? 8 : 4;
        localparam int H = (g == 0) ? 6 : 2;
        localparam int F = (g == 0) ? 3 : 1;
        localparam int L = (g == 0) ? 2 : 0;
        localparam int OW = W - F + 1;
        localparam int OH = H - F + 1;
        localparam int NOUT = S2 ? ((OW + 1) / 2) * ((OH + 1) / 2) : OW * OH;

        logic busy_w, done_w, ir_w, wen_w, ren_w, wv, ov, ol;
        logic [AW-1:0] waddr, raddr, col_w, row_w;

        filter_line_ctrl #(.IMG_W(W), .IMG_H(H), .FN(F), .ADDR_W(AW), .FILTER_LAT(L)) dut (
            .clk(clk), .reset(rst), .start(st[g]), .busy(busy_w), .done(done_w),
            .in_valid(iv[g]), .in_ready(ir_w), .lb_wen(wen_w), .lb_waddr(waddr),
            .lb_ren(ren_w), .lb_raddr(raddr), .col(col_w), .row(row_w),
            .win_valid(wv), .out_valid(ov), .out_last(ol)
        );

        assign rdy[g]    = ir_w;
        assign dn[g]     = done_w;
        assign anyout[g] = |{busy_w, done_w, ir_w, wen_w, waddr, ren_w, raddr, col_w, row_w, wv, ov, ol};

        int  wq[$], oq[$];
        bit  lq[$];
        bit  active = 1'b0, ren_exp = 1'b0, we, oe, le, acc;
        int  n = 0, nq = 0, outs = 0, frames = 0, done_exp = -1;
        int  r, c, last_r = 0, last_c = 0;

        always @(negedge clk) begin
            if (rst) begin
                active = 1'b0; ren_exp = 1'b0; n = 0; done_exp = -1;
                wq.delete(); oq.delete(); lq.delete();
            end else begin
                chk($sformatf("busy%0d", g), busy_w, active || st[g]);
                chk($sformatf("in_ready%0d", g), ir_w, active && n < W * H);
                chk($sformatf("lb_ren%0d", g), ren_w, ren_exp);
                if (ren_exp) begin
                    chk($sformatf("lb_raddr%0d", g), raddr, last_c);
                    chk($sformatf("col%0d", g), col_w, last_c);
                    chk($sformatf("row%0d", g), row_w, last_r);
                end
                ren_exp = 1'b0;
                acc = iv[g] && ir_w;
                chk($sformatf("lb_wen%0d", g), wen_w, acc);
                if (acc) begin
                    r = n / W;
                    c = n % W;
                    chk($sformatf("lb_waddr%0d", g), waddr, c);
                    ren_exp = 1'b1; last_r = r; last_c = c; n++;
                    if (r >= F - 1 && c >= F - 1 &&
                        (!S2 || (((r - (F - 1)) % 2 == 0) && ((c - (F - 1)) % 2 == 0)))) begin
                        nq++;
                        wq.push_back(cyc + 2);
                        oq.push_back(cyc + 2 + L);
                        lq.push_back(nq == NOUT);
                    end
                end
                we = (wq.size() > 0) && (wq[0] == cyc);
                if (wv || we) begin
                    chk($sformatf("win_valid%0d", g), wv, we);
                    if (we) void'(wq.pop_front());
                end
                oe = (oq.size() > 0) && (oq[0] == cyc);
                if (ov || oe) chk($sformatf("out_valid%0d", g), ov, oe);
                if (oe) begin
                    void'(oq.pop_front());
                    le = lq.pop_front();
                    outs++;
                    chk($sformatf("out_last%0d", g), ol, le);
                    if (le) done_exp = cyc + 1;
                end else if (ol) begin
                    chk($sformatf("out_last_stray%0d", g), ol, 0);
                end
                if (done_w || cyc == done_exp) begin
                    chk($sformatf("done%0d", g), done_w, cyc == done_exp);
                    if (cyc == done_exp) begin
                        chk($sformatf("nout%0d", g), outs, NOUT);
                        active = 1'b0; frames++; done_exp = -1;
                    end
                end
                if (st[g] && !active) begin
                    active = 1'b1; n = 0; nq = 0; outs = 0;
                end
            end
        end
    end

    // mode 0: in_valid held high, 1: toggling, 2: random. abort_at>0 resets after that many accepts.
    task automatic frame(input int g, input int mode, input int abort_at, input int restart_at);
        int acc = 0;
        int cnt = 0;
        bit seen = 1'b0;
        st[g] = 1'b1;
        @(posedge clk); #1;
        st[g] = 1'b0;
        while (!seen && cnt < 3000) begin
            iv[g] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cnt % 2 == 0) : 1'($urandom_range(0, 1));
            st[g] = (cnt == restart_at);
            @(negedge clk);
            if (iv[g] && rdy[g]) acc++;
            if (dn[g]) seen = 1'b1;
            if (abort_at > 0 && acc == abort_at) begin
                @(posedge clk); #1;
                rst = 1'b1; iv[g] = 1'b0; st[g] = 1'b0;
                @(negedge clk);
                chk("reset_outs0", anyout[0], 0);
                chk("reset_outs1", anyout[1], 0);
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            cnt++;
        end
        iv[g] = 1'b0;
        st[g] = 1'b0;
        if (!seen) chk("frame_timeout", cnt, -1);
    endtask

    initial begin
        rst = 1'b1; st = '0; iv = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state0", anyout[0], 0);
        chk("reset_state1", anyout[1], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        frame(0, 0, 0, -1);
        frame(0, 1, 0, -1);
        frame(0, 2, 20, -1);
        repeat (30) @(posedge clk); #1;
        frame(0, 0, 0, -1);
        frame(0, 2, 0, 15);
        frame(1, 2, 0, -1);
        frame(1, 0, 0, -1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("frames0", u[0].frames, 4);
        chk("frames1", u[1].frames, 2);
        chk("pending0", u[0].oq.size() + u[0].wq.size(), 0);
        chk("pending1", u[1].oq.size() + u[1].wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
